// File: rtl/pulse_swallow_ctr.sv
// Pulse-swallow counter behind an 8/9 dual-modulus prescaler: frames of P' clk cycles,
// with mc high for the first S' of them, giving an overall VCO division of 8*P' + S'.
module pulse_swallow_ctr #(
  parameter int P_W = 8,
  parameter int S_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [P_W-1:0] p_val,
  input  logic [S_W-1:0] s_val,
  output logic           mc,
  output logic           div_out,
  output logic           load
);

  localparam int C_W = (P_W > S_W) ? P_W : S_W;

  logic [P_W-1:0] p_cnt;
  logic [S_W-1:0] s_rem;

  logic           load_edge;
  logic [P_W-1:0] p_eff;
  logic [C_W-1:0] p_ext;
  logic [C_W-1:0] s_ext;
  logic [S_W-1:0] s_eff;
  logic [S_W-1:0] s_dec;

  // Sanitise P/S at the load edge; the clamp of S to P' never exceeds s_val, so it fits in S_W bits.
  always_comb begin
    load_edge = (p_cnt == '0);
    p_eff     = (p_val == '0) ? P_W'(1) : p_val;
    p_ext     = C_W'(p_eff);
    s_ext     = C_W'(s_val);
    s_eff     = (s_ext > p_ext) ? p_ext[S_W-1:0] : s_val;
    s_dec     = (s_rem != '0) ? (s_rem - S_W'(1)) : s_rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_cnt   <= '0;
      s_rem   <= '0;
      mc      <= 1'b0;
      div_out <= 1'b0;
      load    <= 1'b0;
    end else if (load_edge) begin
      p_cnt   <= p_eff - P_W'(1);
      s_rem   <= s_eff;
      mc      <= (s_eff != '0);
      div_out <= 1'b1;
      load    <= 1'b1;
    end else begin
      p_cnt   <= p_cnt - P_W'(1);
      s_rem   <= s_dec;
      mc      <= (s_dec != '0);
      div_out <= 1'b0;
      load    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_swallow_ctr.sv
// Self-checking bench for pulse_swallow_ctr: directed frames plus random P/S and resets,
// checked cycle by cycle against a frame-level model (frame length, swallow count, VCO total).
module tb_pulse_swallow_ctr;

  localparam int P_W = 8;
  localparam int S_W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [P_W-1:0] p_val = '0;
  logic [S_W-1:0] s_val = '0;
  logic           mc;
  logic           div_out;
  logic           load;

  int compared = 0;
  int mismatched = 0;

  // Frame-level reference: current frame length/swallow count and position inside it.
  int  frame_len = 1;
  int  s_len = 0;
  int  pos = 0;
  bit  fresh = 1'b1;
  bit  vco_valid = 1'b0;
  int  vco_acc = 0;

  pulse_swallow_ctr #(.P_W(P_W), .S_W(S_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .p_val   (p_val),
    .s_val   (s_val),
    .mc      (mc),
    .div_out (div_out),
    .load    (load)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clk edge: the model decides what this edge should produce, then the DUT is compared.
  task automatic stepCycle();
    int p_now;
    int s_now;
    @(posedge clk);
    #1;
    if (fresh || (pos + 1 == frame_len)) begin
      if (vco_valid)
        checkOutput("vco_per_frame", vco_acc, 8 * frame_len + s_len);
      p_now     = int'(p_val);
      s_now     = int'(s_val);
      frame_len = (p_now == 0) ? 1 : p_now;
      s_len     = (s_now > frame_len) ? frame_len : s_now;
      pos       = 0;
      vco_acc   = 0;
      vco_valid = 1'b1;
      fresh     = 1'b0;
    end else begin
      pos++;
    end
    checkOutput("div_out", int'(div_out), (pos == 0) ? 1 : 0);
    checkOutput("load", int'(load), (pos == 0) ? 1 : 0);
    checkOutput("mc", int'(mc), (pos < s_len) ? 1 : 0);
    vco_acc += mc ? 9 : 8;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic applyStimulus(input int p, input int s);
    p_val = P_W'(p);
    s_val = S_W'(s);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock edge.
  task automatic pulseReset();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mc", int'(mc), 0);
    checkOutput("rst_div_out", int'(div_out), 0);
    checkOutput("rst_load", int'(load), 0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_div_out", int'(div_out), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    fresh     = 1'b1;
    vco_valid = 1'b0;
    vco_acc   = 0;
  endtask

  initial begin
    int s_next;
    int found;

    $display("[TB] start");
    applyStimulus(10, 3);
    #3;
    checkOutput("init_mc", int'(mc), 0);
    checkOutput("init_div_out", int'(div_out), 0);
    checkOutput("init_load", int'(load), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic 10/3 frames (83 VCO cycles each)
    runCycles(31);

    // S clamp: 5/9 -> mc constantly high, 45 VCO cycles
    applyStimulus(5, 9);
    runCycles(21);

    // P = 0 -> P' = 1, div_out stuck high, 8 per frame
    applyStimulus(0, 0);
    runCycles(16);

    // P = 1, S = 1 -> mc stuck high, 9 per frame
    applyStimulus(1, 1);
    runCycles(8);

    // Mid-frame change from 10/3 to 12/7 during cycle 4
    pulseReset();
    applyStimulus(10, 3);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      stepCycle();
      if (pos == 4 && frame_len == 10) found = 1;
    end
    checkOutput("midframe_reached", found, 1);
    applyStimulus(12, 7);
    runCycles(6 + 12 * 2 + 1);

    // Fractional sequence: P = 20, S stepping 0..7 each load pulse -> 160..167
    pulseReset();
    applyStimulus(20, 0);
    s_next = 0;
    for (int i = 0; i < 8 * 20 + 1; i++) begin
      stepCycle();
      if (pos == 0 && s_next < 7) begin
        s_next++;
        s_val = S_W'(s_next);
      end
    end

    // Reset in cycle 6 of a 10/3 frame
    pulseReset();
    applyStimulus(10, 3);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      stepCycle();
      if (pos == 6 && frame_len == 10) found = 1;
    end
    checkOutput("cycle6_reached", found, 1);
    pulseReset();
    runCycles(12);

    // Randomized P/S changes at arbitrary points, with occasional resets
    for (int i = 0; i < 2500; i++) begin
      stepCycle();
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 19) == 0)
          p_val = P_W'($urandom_range(0, 255));
        else
          p_val = P_W'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 3) == 0)
        s_val = S_W'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0)
        pulseReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
